// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a word-wide, single-write-enable data memory.
// Byte and half stores are done as read-modify-write. Load data is lane
// extracted and sign/zero extended. Errors (illegal size, misalignment,
// out of range) complete without touching memory.
//
// Handshake: a request is taken on the rising edge where i_req_valid and
// o_req_ready are both high; o_req_ready is high only while idle. The
// response is a single-cycle o_rsp_valid pulse with no backpressure, and
// o_rsp_rdata/o_rsp_err are meaningful only while o_rsp_valid is high.
module lsu_ctrl #(
  parameter int          MEM_AW    = 13,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_wren,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic [2:0]        o_dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RDW  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  logic [2:0]        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_lane;
  logic [MEM_AW-1:0] r_widx;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic [31:0]       w_off;
  logic              w_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  // Byte offset into the memory window; a wrap (addr < base) is caught separately.
  assign w_off = i_req_addr - BASE_ADDR;

  assign w_err = (i_req_size == 2'b11)
               | ((i_req_size == 2'b01) & i_req_addr[0])
               | ((i_req_size == 2'b10) & (|i_req_addr[1:0]))
               | (i_req_addr < BASE_ADDR)
               | ((w_off >> (MEM_AW + 2)) != 32'd0);

  // Lane extraction for loads and lane merge for sub-word stores, from the sampled word.
  always_comb begin
    w_byte  = i_mem_rdata[{r_lane, 3'b000} +: 8];
    w_half  = i_mem_rdata[{r_lane[1], 4'b0000} +: 16];
    w_load  = i_mem_rdata;
    w_merge = i_mem_rdata;
    case (r_size)
      2'b00: begin
        w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
        w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
        w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: begin
        w_load  = i_mem_rdata;
        w_merge = i_mem_rdata;
      end
    endcase
  end

  // Request latch and sequencing; memory data is sampled on the edge leaving RDW.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_widx     <= '0;
      r_wdata    <= 32'd0;
      r_err      <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_lane     <= i_req_addr[1:0];
            r_widx     <= w_off[MEM_AW+1:2];
            r_wdata    <= i_req_wdata;
            r_err      <= w_err;
            r_rdata    <= 32'd0;
            if (w_err)
              r_state <= S_RSP;
            else if (i_req_we && (i_req_size == 2'b10))
              r_state <= S_WR;
            else
              r_state <= S_RD;
          end
        end
        S_RD:  r_state <= S_RDW;
        S_RDW: begin
          if (r_we) begin
            r_wdata <= w_merge;
            r_state <= S_WR;
          end else begin
            r_rdata <= w_load;
            r_state <= S_RSP;
          end
        end
        S_WR:    r_state <= S_RSP;
        S_RSP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so a reset drops them immediately.
  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RSP);
  assign o_rsp_rdata = (r_state == S_RSP) ? r_rdata : 32'd0;
  assign o_rsp_err   = (r_state == S_RSP) & r_err;
  assign o_mem_wren  = (r_state == S_WR);
  assign o_mem_addr  = ((r_state == S_RD) || (r_state == S_RDW) || (r_state == S_WR)) ? r_widx : '0;
  assign o_mem_wdata = (r_state == S_WR) ? r_wdata : 32'd0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus random traffic against a
// word-array reference model, with a registered-read data memory model.
module tb_lsu_ctrl;

  localparam int          MEM_AW = 13;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          DEPTH  = 1 << MEM_AW;
  localparam int          W      = 33;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [1:0]        i_req_size;
  logic              i_req_unsigned;
  logic [31:0]       i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;
  logic              o_mem_wren;
  logic [MEM_AW-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;
  logic [2:0]        o_dbg_state;

  lsu_ctrl #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_dbg_state(o_dbg_state)
  );

  // clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // data memory with a one-cycle registered read
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] mem_q;
  always @(posedge i_clk) begin
    if (o_mem_wren) mem[o_mem_addr] <= o_mem_wdata;
    mem_q <= mem[o_mem_addr];
  end
  assign i_mem_rdata = mem_q;

  // scoreboard state
  int          checks;
  int          errors;
  int          n_req;
  int          last_wait;
  int          wr_cnt;
  int          rsp_cnt;
  logic [MEM_AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // write-port and response monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_mem_wren) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = o_mem_addr;
      wr_data = o_mem_wdata;
    end
    if (o_rsp_valid) rsp_cnt = rsp_cnt + 1;
  end

  // One request end to end: model, drive, wait, check.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input bit keep,
                        output logic [31:0] got);
    logic        err;
    logic [31:0] off, old, nw, rd;
    int          idx, sh, lat, lat_exp, wrs, wait_n;
    logic [W-1:0] e;
    off = a - BASE;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
          || (a < BASE) || ((off >> 2) >= 32'(DEPTH));
    idx = err ? 0 : int'(off >> 2);
    old = ref_mem[idx];
    sh  = 8 * int'(a[1:0]);
    rd  = 32'd0;
    nw  = old;
    if (err) lat_exp = 1;
    else if (we) begin
      case (sz)
        2'b00:   nw = (old & ~(32'hFF << sh))   | ((wd & 32'hFF) << sh);
        2'b01:   nw = (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        default: nw = wd;
      endcase
      lat_exp = (sz == 2'b10) ? 2 : 4;
    end else begin
      case (sz)
        2'b00: begin
          rd = (old >> sh) & 32'hFF;
          if (!uns && rd >= 32'd128) rd = rd - 32'd256;
        end
        2'b01: begin
          rd = (old >> sh) & 32'hFFFF;
          if (!uns && rd >= 32'd32768) rd = rd - 32'd65536;
        end
        default: rd = old;
      endcase
      lat_exp = 3;
    end
    exp_q.push_back({err, rd});
    wrs = wr_cnt;
    got = 32'd0;

    i_req_we = we; i_req_size = sz; i_req_unsigned = uns;
    i_req_addr = a; i_req_wdata = wd; i_req_valid = 1'b1;
    wait_n = 0;
    while (!o_req_ready && wait_n < 20) begin
      @(posedge i_clk); #1;
      wait_n++;
    end
    last_wait = wait_n;
    if (!o_req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
      i_req_valid = 1'b0;
      return;
    end
    @(posedge i_clk); #1;
    if (!keep) i_req_valid = 1'b0;
    n_req++;

    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      chk("ready_busy", 32'(o_req_ready), 32'd0);
      @(posedge i_clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_exp));
    e = exp_q.pop_front();
    if (o_rsp_valid) begin
      chk("ready_in_rsp", 32'(o_req_ready), 32'd0);
      chk("rsp_err", 32'(o_rsp_err), 32'(e[32]));
      chk("rsp_rdata", o_rsp_rdata, e[31:0]);
      got = o_rsp_rdata;
    end else begin
      chk("rsp_timeout", 32'd0, 32'd1);
    end
    chk("wren_count", 32'(wr_cnt - wrs), (!err && we) ? 32'd1 : 32'd0);
    if (!err && we) begin
      chk("wr_addr", 32'(wr_addr), 32'(idx));
      chk("wr_data", wr_data, nw);
      ref_mem[idx] = nw;
    end
    @(posedge i_clk); #1;
    chk("rsp_one_cycle", 32'(o_rsp_valid), 32'd0);
    chk("ready_idle", 32'(o_req_ready), 32'd1);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] g;
  initial begin
    int wrs0, rsps0;
    logic [1:0] rsz;
    logic [31:0] ra;
    checks = 0; errors = 0; n_req = 0; last_wait = 0; wr_cnt = 0; rsp_cnt = 0;
    wr_addr = '0; wr_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'b00;
    i_req_unsigned = 1'b0; i_req_addr = 32'd0; i_req_wdata = 32'd0;

    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("rst_wren", 32'(o_mem_wren), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_wdata", o_mem_wdata, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // word store then load
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, g);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, g);
    chk("t1_load", g, 32'hA5A5A5A5);

    // byte stores over a known word
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h12345678, 1'b0, g);
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000003C, 1'b0, g);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, g);
    chk("t2_word", g, 32'h12343C78);
    do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1'b0, g);
    chk("t2_lb5", g, 32'h0000003C);
    do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h000000F0, 1'b0, g);
    do_req(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 1'b0, g);
    chk("t2_lb6", g, 32'hFFFFFFF0);
    do_req(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 1'b0, g);
    chk("t2_lbu6", g, 32'h000000F0);

    // half store
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, g);
    do_req(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000BEEF, 1'b0, g);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, g);
    chk("t3_word", g, 32'hBEEFA5A5);
    do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 1'b0, g);
    chk("t3_lh", g, 32'hFFFFBEEF);
    do_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 1'b0, g);
    chk("t3_lhu", g, 32'h0000BEEF);

    // error cases
    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b0, g);
    do_req(1'b1, 2'b01, 1'b0, 32'h3, 32'hFFFF, 1'b0, g);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0, g);
    do_req(1'b0, 2'b10, 1'b0, 32'h8000, 32'h0, 1'b0, g);
    do_req(1'b1, 2'b10, 1'b0, 32'h7FFC, 32'hCAFEF00D, 1'b0, g);
    do_req(1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0, 1'b0, g);
    chk("top_word", g, 32'hCAFEF00D);

    // reset during RDW of a byte store
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0, g);
    wrs0 = wr_cnt; rsps0 = rsp_cnt;
    i_req_we = 1'b1; i_req_size = 2'b00; i_req_unsigned = 1'b0;
    i_req_addr = 32'h1; i_req_wdata = 32'h000000EE; i_req_valid = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_wren", 32'(o_mem_wren), 32'd0);
    chk("rst_mid_ready", 32'(o_req_ready), 32'd1);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    chk("rst_mid_ready_after", 32'(o_req_ready), 32'd1);
    chk("rst_mid_no_write", 32'(wr_cnt - wrs0), 32'd0);
    chk("rst_mid_no_rsp", 32'(rsp_cnt - rsps0), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, g);
    chk("rst_mid_word", g, 32'h11223344);

    // back-to-back with valid held high
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h00000077, 1'b1, g);
    do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b0, g);
    chk("b2b_wait", 32'(last_wait), 32'd0);
    chk("b2b_data", g, 32'h00000077);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rsz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1:       ra = 32'h7FF0 + 32'($urandom_range(0, 31));
        default: ra = 32'($urandom_range(0, 63));
      endcase
      do_req(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0, g);
    end

    chk("rsp_total", 32'(rsp_cnt), 32'(n_req));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
